// File: rtl/ppa_kogge_stone_19bit_pkg.sv
`default_nettype none
// ============================================================================
// Package     : ppa_pkg
// Description : Shared helpers for the Kogge-Stone parallel-prefix adder.
//               ks_stages(width) returns ceil(log2(width)), which is the
//               number of prefix stages. PPA_MAX_WIDTH is the widest legal
//               operand.
// Revision    : 1.0 - initial release
// ============================================================================
package ppa_pkg;

  localparam int PPA_MAX_WIDTH = 64;

  // ceil(log2(width)); a width of 1 or less needs no prefix stage.
  function automatic int ks_stages(input int width);
    int stages;
    stages = 0;
    while ((1 << stages) < width) begin
      stages = stages + 1;
    end
    return stages;
  endfunction

endpackage : ppa_pkg
`default_nettype wire

// File: rtl/ppa_kogge_stone_19bit_black_cell.sv
`default_nettype none
// ============================================================================
// Module      : ks_black_cell
// Description : Kogge-Stone prefix operator. It combines the group
//               generate/propagate pair (Gi,Pi) of a span with the pair of
//               the adjacent lower span (Gj,Pj).
// Ports       : Gi, Pi - upper span generate/propagate (in)
//               Gj, Pj - lower span generate/propagate (in)
//               Go, Po - combined span generate/propagate (out)
// Revision    : 1.0 - initial release
// ============================================================================
module ks_black_cell (
  input  logic Gi,
  input  logic Pi,
  input  logic Gj,
  input  logic Pj,
  output logic Go,
  output logic Po
);

  assign Go = Gi | (Pi & Gj);
  assign Po = Pi & Pj;

endmodule : ks_black_cell
`default_nettype wire

// File: rtl/ppa_kogge_stone_19bit.sv
`default_nettype none
// ============================================================================
// Module      : ppa_kogge_stone_19bit
// Description : Kogge-Stone parallel-prefix adder. It computes
//               {cout,S} = A + B + cin over `width` bits.
//               The default build is purely combinational, and clk and rst_n
//               are ignored. When the macro PPA_KS_OUTPUT_REG_EN is defined,
//               S and cout are registered on the rising edge of clk. In that
//               build, rst_n is an asynchronous active-low clear.
// Ports       : clk   - block clock (registered build only)
//               rst_n - async active-low reset (registered build only)
//               A, B  - unsigned addends, width bits
//               cin   - carry in
//               S     - sum, bits [width-1:0]
//               cout  - carry out, bit [width]
// Revision    : 1.0 - initial release
// ============================================================================
module ppa_kogge_stone_19bit
  import ppa_pkg::*;
#(
  parameter int width = 19
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [width-1:0] A,
  input  logic [width-1:0] B,
  input  logic             cin,
  output logic [width-1:0] S,
  output logic             cout
);

  localparam int c_STAGES = ks_stages(width);

  if ((width < 2) || (width > PPA_MAX_WIDTH)) begin : g_bad_width
    $error("ppa_kogge_stone_19bit: width out of range 2..64");
  end

  logic [width-1:0] p_w;
  logic [width-1:0] g_w;
  logic [width-1:0] g0_w;
  logic [width:0]   c_w;
  logic [width-1:0] s_d;
  logic             cout_d;

  assign p_w = A ^ B;
  assign g_w = A & B;

  // Fold cin into bit 0. Every carry then falls out of the tree as a
  // group generate, and no extra prefix column is needed.
  assign g0_w = {g_w[width-1:1], g_w[0] | (p_w[0] & cin)};

  for (genvar k = 0; k < c_STAGES; k++) begin : g_stage
    localparam int c_DIST = 1 << k;
    logic [width-1:0] g_in;
    logic [width-1:0] p_in;
    logic [width-1:0] g_out;
    logic [width-1:0] p_out;

    if (k == 0) begin : g_first
      assign g_in = g0_w;
      assign p_in = p_w;
    end else begin : g_next
      assign g_in = g_stage[k-1].g_out;
      assign p_in = g_stage[k-1].p_out;
    end

    for (genvar i = 0; i < width; i++) begin : g_bit
      if (i >= c_DIST) begin : g_cell
        ks_black_cell u_cell (
          .Gi (g_in[i]),
          .Pi (p_in[i]),
          .Gj (g_in[i-c_DIST]),
          .Pj (p_in[i-c_DIST]),
          .Go (g_out[i]),
          .Po (p_out[i])
        );
      end else begin : g_pass
        assign g_out[i] = g_in[i];
        assign p_out[i] = p_in[i];
      end
    end
  end

  // Final group generate of bit i is the carry into bit i+1.
  assign c_w    = {g_stage[c_STAGES-1].g_out, cin};
  assign s_d    = p_w ^ c_w[width-1:0];
  assign cout_d = c_w[width];

`ifdef PPA_KS_OUTPUT_REG_EN
  logic [width-1:0] s_q;
  logic             cout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q    <= '0;
      cout_q <= 1'b0;
    end else begin
      s_q    <= s_d;
      cout_q <= cout_d;
    end
  end

  assign S    = s_q;
  assign cout = cout_q;

  // The last stage's group propagate has no consumer.
  logic unused_ok;
  assign unused_ok = ^g_stage[c_STAGES-1].p_out;
`else
  assign S    = s_d;
  assign cout = cout_d;

  // clk and rst_n have no function in the combinational build.
  logic unused_ok;
  assign unused_ok = clk ^ rst_n ^ (^g_stage[c_STAGES-1].p_out);
`endif

endmodule : ppa_kogge_stone_19bit
`default_nettype wire

// File: tb/tb_ppa_kogge_stone_19bit.sv
`default_nettype none
// ============================================================================
// Module      : tb_ppa_kogge_stone_19bit
// Description : Directed plus random self-checking bench for the 19-bit
//               Kogge-Stone adder. It covers the combinational build and,
//               when PPA_KS_OUTPUT_REG_EN is defined, the registered build.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ppa_kogge_stone_19bit;

  localparam int W = 19;

  logic          clk;
  logic          rst_n;
  logic [W-1:0]  A;
  logic [W-1:0]  B;
  logic          cin;
  logic [W-1:0]  S;
  logic          cout;

  int checks = 0;
  int errors = 0;

  ppa_kogge_stone_19bit #(.width(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (A),
    .B     (B),
    .cin   (cin),
    .S     (S),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] s_exp, input logic c_exp);
    checks++;
    assert ({cout, S} === {c_exp, s_exp})
    else begin
      errors++;
      $error("FAIL %s: observed cout=%b S=0x%05h, expected cout=%b S=0x%05h",
             tag, cout, S, c_exp, s_exp);
    end
  endtask

  // Drive one vector and check it once the result is available.
  // Combinational build: the vector is held for 10 time units.
  // Registered build: the vector is driven on a falling edge, and the result
  // is checked just after the next rising edge.
  task automatic apply(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic ci, input logic [W-1:0] s_exp, input logic c_exp);
`ifdef PPA_KS_OUTPUT_REG_EN
    @(negedge clk);
    A = a; B = b; cin = ci;
    @(posedge clk);
    #1;
`else
    A = a; B = b; cin = ci;
    #10;
`endif
    check(tag, s_exp, c_exp);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rc;
    logic [W:0]   rsum;
    int           rand_pass;
    int           rand_n;

    A = '0; B = '0; cin = 1'b0;
    rst_n = 1'b0;

`ifdef PPA_KS_OUTPUT_REG_EN
    #12;
    check("reset_state", 19'h00000, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    A = 19'h00001; B = 19'h00001; cin = 1'b0;
    #1;
    check("latency_before_edge", 19'h00000, 1'b0);
    @(posedge clk);
    #1;
    check("latency_one_edge", 19'h00002, 1'b0);
`else
    #10;
    rst_n = 1'b1;
`endif

    apply("zero",           19'h00000, 19'h00000, 1'b0, 19'h00000, 1'b0);
    apply("full_propagate", 19'h7FFFF, 19'h00000, 1'b1, 19'h00000, 1'b1);
    apply("alt_cin0",       19'h2AAAA, 19'h55555, 1'b0, 19'h7FFFF, 1'b0);
    apply("alt_cin1",       19'h2AAAA, 19'h55555, 1'b1, 19'h00000, 1'b1);
    apply("max",            19'h7FFFF, 19'h7FFFF, 1'b1, 19'h7FFFF, 1'b1);
    apply("cin_only",       19'h00000, 19'h00000, 1'b1, 19'h00001, 1'b0);
    apply("msb_carry",      19'h40000, 19'h40000, 1'b0, 19'h00000, 1'b1);
    apply("span16",         19'h0FFFF, 19'h00001, 1'b0, 19'h10000, 1'b0);
    apply("mixed",          19'h12345, 19'h00001, 1'b0, 19'h12346, 1'b0);
    apply("mixed2",         19'h3C3C3, 19'h43C3C, 1'b1, 19'h00000, 1'b1);

    rand_pass = 0;
    rand_n    = 60;
    for (int i = 0; i < rand_n; i++) begin
      int e0;
      ra   = W'($urandom_range(0, 32'h7FFFF));
      rb   = W'($urandom_range(0, 32'h7FFFF));
      rc   = 1'($urandom_range(0, 1));
      rsum = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      e0   = errors;
      apply("random", ra, rb, rc, rsum[W-1:0], rsum[W]);
      if (errors == e0) rand_pass++;
    end
    $display("random vectors: %0d of %0d passed (%0d%%)", rand_pass, rand_n,
             (rand_pass * 100) / rand_n);

`ifdef PPA_KS_OUTPUT_REG_EN
    // Reset in mid-stream: the output clears at once, without waiting for an
    // edge, and the in-flight result is discarded.
    @(negedge clk);
    A = 19'h00005; B = 19'h00003; cin = 1'b0;
    @(posedge clk);
    #1;
    check("pre_reset_value", 19'h00008, 1'b0);
    A = 19'h7FFFF; B = 19'h7FFFF; cin = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_clear", 19'h00000, 1'b0);
    @(posedge clk);
    #1;
    check("reset_holds_over_edge", 19'h00000, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("first_edge_after_reset", 19'h7FFFF, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_ppa_kogge_stone_19bit
`default_nettype wire
